// File: rtl/tx_frame_arbiter_pkg.sv
// Shared constants and types for the TX frame arbiter.
package tx_frame_arbiter_pkg;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_RD  = 2'd1;
  localparam logic [1:0] SRC_ERR = 2'd2;

  localparam logic [7:0] ERR_HDR_DEF = 8'hEE;

  localparam int unsigned FRAME_LEN_ALU = 2;
  localparam int unsigned FRAME_LEN_RD  = 1;
  localparam int unsigned FRAME_LEN_ERR = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Index of the final byte of a source's frame (all frames are 1 or 2 bytes).
  function automatic logic last_idx(input logic [1:0] src);
    case (src)
      SRC_ALU: last_idx = 1'(FRAME_LEN_ALU - 1);
      SRC_RD:  last_idx = 1'(FRAME_LEN_RD - 1);
      default: last_idx = 1'(FRAME_LEN_ERR - 1);
    endcase
  endfunction

endpackage

// File: rtl/tx_frame_arbiter_rr_arb3.sv
// Three-requester round-robin grant; the pointer register lives in the parent.
module rr_arb3 (
  input  logic [2:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [2:0] gnt_o,
  output logic [1:0] gnt_idx_o
);

  int unsigned cand;

  // Scan requesters starting at the pointer, first hit wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    cand      = 0;
    for (int unsigned k = 0; k < 3; k++) begin
      cand = (int'(ptr_i) + k) % 3;
      if (req_i[cand] && (gnt_o == '0)) begin
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = 2'(cand);
      end
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Serialises ALU / register-read / error frames into the TX FIFO write port.
module tx_frame_arbiter
  import tx_frame_arbiter_pkg::*;
#(
  parameter int unsigned     DSIZE    = 8,
  parameter int unsigned     OUT_SIZE = 2 * DSIZE,
  parameter logic [DSIZE-1:0] ERR_HDR = ERR_HDR_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [OUT_SIZE-1:0] ALU_OUT,
  input  logic                OUT_VALID,
  input  logic [DSIZE-1:0]    RD_DATA,
  input  logic                RD_VLD,
  input  logic [DSIZE-1:0]    ERR_CODE,
  input  logic                ERR_VLD,
  input  logic                FIFO_FULL,
  output logic [DSIZE-1:0]    FIFO_WR_DATA,
  output logic                FIFO_W_INC,
  output logic                BUSY,
  output logic                OVF
);

  state_e              state_q, state_d;
  logic [2:0]          pend_q, pend_d;
  logic [OUT_SIZE-1:0] alu_buf_q, alu_buf_d;
  logic [DSIZE-1:0]    rd_buf_q, rd_buf_d;
  logic [DSIZE-1:0]    err_buf_q, err_buf_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          rr_q, rr_d;
  logic                idx_q, idx_d;
  logic                ovf_q, ovf_d;

  logic [2:0]          arb_gnt;
  logic [1:0]          arb_idx;
  logic                wr;
  logic                last_byte;
  logic [2:0]          fin;
  logic [2:0]          vld;
  logic [2:0]          accept;
  logic [DSIZE-1:0]    byte_sel;

  rr_arb3 u_arb (
    .req_i     (pend_q),
    .ptr_i     (rr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  // Write strobe, final-byte detection and output byte selection.
  always_comb begin
    wr        = (state_q == SEND) && !FIFO_FULL;
    last_byte = (idx_q == last_idx(grant_q));
    fin       = (wr && last_byte) ? (3'b001 << grant_q) : 3'b000;
    case (grant_q)
      SRC_ALU: byte_sel = idx_q ? alu_buf_q[2*DSIZE-1:DSIZE] : alu_buf_q[DSIZE-1:0];
      SRC_RD:  byte_sel = rd_buf_q;
      SRC_ERR: byte_sel = idx_q ? err_buf_q : ERR_HDR;
      default: byte_sel = '0;
    endcase
  end

  // Capture: a pulse is taken if the source is idle or finishing its last byte now.
  always_comb begin
    vld       = {ERR_VLD, RD_VLD, OUT_VALID};
    accept    = vld & (~pend_q | fin);
    pend_d    = (pend_q & ~fin) | accept;
    ovf_d     = |(vld & ~accept);
    alu_buf_d = accept[SRC_ALU] ? ALU_OUT  : alu_buf_q;
    rd_buf_d  = accept[SRC_RD]  ? RD_DATA  : rd_buf_q;
    err_buf_d = accept[SRC_ERR] ? ERR_CODE : err_buf_q;
  end

  // Arbitration and byte sequencing.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          grant_d = arb_idx;
          idx_d   = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (wr) begin
          if (last_byte) begin
            state_d = IDLE;
            rr_d    = (grant_q == SRC_ERR) ? SRC_ALU : grant_q + 2'd1;
          end else begin
            idx_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      alu_buf_q <= '0;
      rd_buf_q  <= '0;
      err_buf_q <= '0;
      grant_q   <= SRC_ALU;
      rr_q      <= SRC_ALU;
      idx_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      alu_buf_q <= alu_buf_d;
      rd_buf_q  <= rd_buf_d;
      err_buf_q <= err_buf_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
    end
  end

  assign FIFO_W_INC   = wr;
  assign FIFO_WR_DATA = (state_q == SEND) ? byte_sel : '0;
  assign BUSY         = (state_q == SEND) || (|pend_q);
  assign OVF          = ovf_q;

endmodule

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
Shares the single TX async-FIFO write port (REF clock domain) among three response sources: ALU results, register-file read data and error reports. Each source has a one-frame holding buffer. A round-robin arbiter grants one pending source at a time. The granted frame is serialised byte-by-byte into the FIFO with FIFO_FULL back-pressure, and frames are never interleaved.

Parameters:
DSIZE, 8, byte width of FIFO data, RD_DATA and ERR_CODE
OUT_SIZE, 16, ALU result width; fixed at 2*DSIZE (frame sent as 2 bytes)
ERR_HDR, 8'hEE, header byte prefixed to every error frame

Ports:
CLK  in  1  REF-domain clock
RST  in  1  asynchronous active-low reset
ALU_OUT  in  OUT_SIZE  ALU result
OUT_VALID  in  1  1-cycle pulse: ALU_OUT valid
RD_DATA  in  DSIZE  register-file read data
RD_VLD  in  1  1-cycle pulse: RD_DATA valid
ERR_CODE  in  DSIZE  error code
ERR_VLD  in  1  1-cycle pulse: ERR_CODE valid
FIFO_FULL  in  1  TX FIFO full (write-domain flag)
FIFO_WR_DATA  out  DSIZE  byte to FIFO
FIFO_W_INC  out  1  FIFO write strobe, one byte per high cycle
BUSY  out  1  high while any frame is pending or being sent
OVF  out  1  1-cycle pulse: a valid pulse was dropped

Behaviour:
- Reset (async, RST=0) clears all pending flags and buffers, state=IDLE, RR pointer=ALU. FIFO_W_INC=0, FIFO_WR_DATA=0, BUSY=0, OVF=0 immediately.
- Frames:
  - ALU frame: 2 bytes, ALU_OUT[7:0] then ALU_OUT[15:8].
  - RD frame: 1 byte, RD_DATA.
  - ERR frame: 2 bytes, ERR_HDR then ERR_CODE.
- Capture: on a source's valid pulse at edge N, its buffer loads and its pending flag sets (visible from N+1), provided the pending flag is clear.
- A pulse while that source is pending is dropped: buffer unchanged, OVF=1 for one cycle (registered).
- Exception: a pulse in the same cycle as that source's final byte write is accepted. Buffer reloads and pending stays 1, with no OVF.
- Buffers never change during their own frame transmission.
- FSM states:
  - IDLE: if any pending, grant = first pending source in rotating order starting at RR pointer; go to SEND with byte_idx=0. Otherwise stay.
  - SEND: FIFO_W_INC = !FIFO_FULL (combinational). FIFO_WR_DATA = granted buffer byte[byte_idx], held stable while FIFO_FULL.
  - On a write of a non-final byte: byte_idx++.
  - On a write of the final byte: clear that pending flag, RR pointer = granted+1 (mod 3), go to IDLE.
- Priority order from reset: ALU > RD > ERR, then rotating.
- Latency: valid pulse at edge N gives first FIFO_W_INC in the cycle after edge N+1 (IDLE arbitrates during cycle N+1), assuming FIFO not full. Consecutive bytes of a frame are back-to-back; there is exactly one IDLE cycle between frames.
- FIFO_FULL high for any number of cycles stalls in SEND with no write and no data change.
- FIFO_WR_DATA=0 in IDLE.
- BUSY = (state==SEND) | any pending.
- Simultaneous valid pulses from all sources are all captured; no loss.

Decomposition:
- Shared package: source index constants (SRC_ALU=0, SRC_RD=1, SRC_ERR=2), state enum (IDLE, SEND), ERR_HDR default, per-source frame length constants (2, 1, 2).
- One sub-module: rr_arb3, a 3-requester round-robin grant.
  - Inputs: req[2:0], ptr[1:0].
  - Outputs: one-hot grant, grant index.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
1. After reset, RD_VLD with RD_DATA=0x5A at edge N -> single FIFO_W_INC cycle after edge N+1 with data 0x5A. BUSY high N+1..write; OVF never.
2. OUT_VALID with ALU_OUT=0x1234 -> two consecutive writes, 0x34 then 0x12, then IDLE.
3. OUT_VALID (0x1234), RD_VLD (0x5A) and ERR_VLD (0x07) in the same cycle -> write sequence 0x34,0x12, gap, 0x5A, gap, 0xEE,0x07. A subsequent simultaneous RD+ALU pair is served RD first only if the RR pointer says so; check ALU is served first since the pointer now points to ALU after ERR.
4. FIFO_FULL raised before ALU byte 1 and held 5 cycles -> no W_INC for 5 cycles, FIFO_WR_DATA held at 0x12, write resumes the cycle FIFO_FULL drops.
5. Second RD_VLD (0xA5) while 0x5A is pending -> OVF one cycle, only 0x5A sent. RD_VLD (0xC3) coincident with 0x5A write cycle -> no OVF, 0xC3 sent as the next RD frame.
6. RST asserted mid-ALU frame after byte 0 -> W_INC=0 at once, BUSY=0. After release, a new RD_VLD is sent normally and no stale 0x12 appears.
